// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch front end for the decode controller. It holds the PC,
//   issues word reads to instruction memory with at most one request in
//   flight, and buffers returned words in a 2-entry queue. The queue head is
//   presented to decode along with its PC and PC+4.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     read request (addr is the PC register)
//   imem_ready        memory accepts the request when high with imem_req
//   imem_rvalid/rdata in-order read response
//   stall             downstream hold; head is not consumed
//   redirect/target   flush queue, drop in-flight word, refetch from target
//   instruction, instr_pc, instr_pc_plus4, instr_valid   queue head (0 when empty)
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        instr_valid
);

  // IDLE: nothing outstanding; WAIT: response will be kept;
  // DROP: response belongs to a flushed path and will be discarded.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, r_req_pc;
  logic [1:0]  r_count, w_count_nxt;
  logic        r_head;
  logic [31:0] r_q_pc  [2];
  logic [31:0] r_q_ins [2];

  logic        w_valid, w_pop, w_push, w_room, w_accept, w_tail;
  logic [31:0] w_target;

  assign w_valid  = (r_count != 2'd0);
  assign w_pop    = w_valid & ~stall & ~redirect;
  assign w_push   = imem_rvalid & (r_state == S_WAIT) & ~redirect;
  // A response only ever arrives with count <= 1: the request was issued
  // with room to spare and nothing else can push while it is in flight.
  assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
  assign w_room   = (w_count_nxt < 2'd2);
  assign w_target = redirect_target & ~32'h3;

  // Issuing in the cycle a kept response returns sustains one word per
  // cycle against single-cycle memory. Gated by rst_n so nothing is
  // requested while reset is held.
  assign imem_req = rst_n & ~redirect & w_room &
                    ((r_state == S_IDLE) | ((r_state == S_WAIT) & imem_rvalid));
  assign w_accept = imem_req & imem_ready;

  // Tail slot: same as head when empty, the other slot when one entry is held.
  assign w_tail = r_head ^ (r_count == 2'd1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)   w_state_nxt = w_accept ? S_WAIT : S_IDLE;
        else if (redirect) w_state_nxt = S_DROP;
      end
      S_DROP: if (imem_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_count  <= '0;
      r_head   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect) begin
        r_pc    <= w_target;
        r_count <= '0;
        r_head  <= 1'b0;
      end else begin
        r_count <= w_count_nxt;
        r_head  <= r_head ^ w_pop;
        if (w_accept) begin
          r_req_pc <= r_pc;
          r_pc     <= r_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_q_pc[i]  <= '0;
        r_q_ins[i] <= '0;
      end
    end else if (w_push) begin
      r_q_pc[w_tail]  <= r_req_pc;
      r_q_ins[w_tail] <= imem_rdata;
    end
  end

  // The address reads as zero while reset is held, like every other output.
  assign imem_addr      = rst_n ? r_pc : '0;
  assign instr_valid    = w_valid;
  assign instruction    = w_valid ? r_q_ins[r_head] : '0;
  assign instr_pc       = w_valid ? r_q_pc[r_head] : '0;
  assign instr_pc_plus4 = w_valid ? (r_q_pc[r_head] + 32'd4) : '0;

endmodule
